noc_inject_arbiter: RTL and testbench
=====================================

Name: noc_inject_arbiter

Overview:
- Packet-level wormhole arbiter that shares one NoC node injection port among NUM_REQ local requesters (e.g. several test or IP sources behind one router local port).
- Grants one requester at a time, round-robin.
- Holds the grant from header to tail so flits never interleave.
- Drives the node's receive_* interface through a registered output stage.

Parameters:
- NUM_REQ, 4, number of requesters (2..8)
- DATA_WIDTH, `Noc_Data_Width, flit width
- ID_W, $clog2(NUM_REQ), width of grant_id

Ports:
- noc_clk  in  1  clock
- noc_rst_n  in  1  asynchronous active-low reset
- req_valid  in  NUM_REQ  per-requester flit valid
- req_ready  out  NUM_REQ  per-requester flit accept
- req_flit  in  NUM_REQ*DATA_WIDTH  packed flits; requester i occupies bits [i*DATA_WIDTH +: DATA_WIDTH]
- req_is_header  in  NUM_REQ  flit is packet header
- req_is_tail  in  NUM_REQ  flit is packet tail
- out_valid  out  1  to node receive_valid
- out_ready  in  1  from node receive_ready
- out_flit  out  DATA_WIDTH  to node receive_flit
- out_is_header  out  1  to node receive_is_header
- out_is_tail  out  1  to node receive_is_tail
- grant_id  out  ID_W  currently or last granted requester
- busy  out  1  high while a packet is locked
- proto_err  out  1  one-cycle pulse on protocol violation

Behaviour:
- Clocking and reset: single clock noc_clk; reset noc_rst_n is asynchronous, active-low.
- Reset values:
  - out_valid, out_flit, out_is_header, out_is_tail, busy, proto_err = 0
  - grant_id = 0
  - rr pointer = NUM_REQ-1, so requester 0 has first priority
  - FSM = IDLE
- FSM states IDLE and LOCKED.
- IDLE:
  - Candidates are requesters i with req_valid[i] & req_is_header[i].
  - Pick the first candidate scanning from rr+1 upward, wrapping modulo NUM_REQ.
  - If any candidate exists: register grant_id, busy <= 1, go to LOCKED.
  - All req_ready = 0 in IDLE. The grant costs one cycle, with no flit transfer that cycle.
- LOCKED:
  - Only the granted requester g may transfer: req_ready[g] = !out_valid | out_ready. All other req_ready = 0.
  - When req_valid[g] & req_ready[g], the flit, header and tail bits load into the output register and out_valid <= 1.
  - If the output register drains without a new load, out_valid <= 0.
  - Throughput is 1 flit/cycle while out_ready stays high.
  - Latency: flit accepted at edge N appears on out_* from edge N until the cycle after N+1.
- Leaving LOCKED: the accepted flit has is_tail=1 → rr <= g, busy <= 0, go to IDLE.
  - A header+tail flit (single-flit packet) also exits.
  - The next grant may be decided in the IDLE cycle while that tail is still in the output register.
- Protocol errors: proto_err pulses for one cycle, with no state change beyond the normal transfer, when any of these occur:
  - First accepted flit in LOCKED lacks is_header.
  - A later flit has is_header.
- Non-header valid flits from any requester in IDLE are not accepted (ready low); they wait.
- Flit stability: out_flit and out_is_* hold stable while out_valid & !out_ready. req_* inputs are sampled only on handshake.
- Deassertions: req_valid[g] dropping mid-packet is legal (bubble); the grant is held. out_ready low indefinitely stalls everything with no loss.
- Reset mid-packet: the FSM returns to IDLE and the output register clears. A partial packet is discarded; the requester must restart from its header.

Optional Feature:
- Macro NOC_INJECT_ARB_STATS_EN.
- When defined: adds output pkt_cnt [NUM_REQ*16], packed like req_flit.
  - Per-requester 16-bit counters, incremented when a tail flit of that requester is accepted.
  - Counters wrap 0xFFFF→0 and reset to 0.
- When undefined: port and counters are absent. Core behaviour is identical.

Decomposition:
- Shared package/include (alongside Noc_parameters) holds:
  - FSM state encodings ARB_IDLE=1'b0, ARB_LOCKED=1'b1
  - Width constant for the stats counter (16)
- One natural sub-module: noc_rr_pick. It is a combinational round-robin selector with inputs cand[NUM_REQ] and ptr[ID_W], and outputs any and idx[ID_W]. It is reusable by router output arbiters.

Test Plan:
- Single requester: after reset, req0 sends a 3-flit packet (H, body, T = 0xA1, 0xA2, 0xA3) with out_ready=1 → grant 1 cycle after header valid; out_flit shows A1, A2, A3 on consecutive cycles; busy drops after the tail; proto_err never asserts.
- Round-robin: all 4 requesters hold single-flit packets continuously → out_is_header order 0,1,2,3,0,1; each packet separated by one IDLE cycle.
- No interleave: req1 mid-packet (5 flits) while req2 raises a header → zero req2 flits appear until req1's tail is out; req2 is granted next.
- Backpressure: out_ready=0 for 4 cycles mid-packet → out_flit stable, req_ready[g]=0, no flit lost or duplicated; the exact sequence resumes.
- Protocol error: granted requester sends a second is_header flit mid-packet → proto_err high exactly 1 cycle; flit still forwarded.
- Reset mid-packet: assert noc_rst_n=0 after 2 of 4 flits → out_valid=0 and busy=0 asynchronously; after release req0 is granted first again.
  - With NOC_INJECT_ARB_STATS_EN: pkt_cnt for every requester reads 0.

Source files
------------

// File: rtl/noc_inject_arbiter_pkg.sv
// Shared definitions for the NoC injection arbiter: FSM encodings and stats width.
// Provides a fallback flit width when the project-wide Noc_parameters is absent.
`ifndef Noc_Data_Width
`define Noc_Data_Width 32
`endif

package noc_inject_arbiter_pkg;

  typedef enum logic {
    ARB_IDLE   = 1'b0,
    ARB_LOCKED = 1'b1
  } arb_state_e;

  localparam int STATS_CNT_W = 16;

endpackage

// File: rtl/noc_rr_pick.sv
// Combinational round-robin selector: first asserted cand after ptr, wrapping.
// Kept generic so router output arbiters can reuse it.
module noc_rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] cand,
  input  logic [ID_W-1:0]    ptr,
  output logic               any,
  output logic [ID_W-1:0]    idx
);

  logic [ID_W-1:0] pos;

  // Scan from the farthest slot back to ptr+1 so the nearest candidate wins last.
  always_comb begin
    any = 1'b0;
    idx = '0;
    pos = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      pos = ID_W'((int'(ptr) + k) % NUM_REQ);
      if (cand[pos]) begin
        any = 1'b1;
        idx = pos;
      end
    end
  end

endmodule

// File: rtl/noc_inject_arbiter.sv
// Wormhole round-robin arbiter sharing one NoC injection port among NUM_REQ
// requesters, with a registered output stage toward the node receive port.
// Optional per-requester packet counters: define NOC_INJECT_ARB_STATS_EN.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// ARB_IDLE   | no packet locked; pick next header round-robin (no transfer)
// ARB_LOCKED | grant_id owns the port until its tail flit is accepted
`ifndef Noc_Data_Width
`define Noc_Data_Width 32
`endif

module noc_inject_arbiter
  import noc_inject_arbiter_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = `Noc_Data_Width,
  parameter int ID_W       = $clog2(NUM_REQ)
) (
  input  logic                          noc_clk,
  input  logic                          noc_rst_n,
  input  logic [NUM_REQ-1:0]            req_valid,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_flit,
  input  logic [NUM_REQ-1:0]            req_is_header,
  input  logic [NUM_REQ-1:0]            req_is_tail,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [DATA_WIDTH-1:0]         out_flit,
  output logic                          out_is_header,
  output logic                          out_is_tail,
  output logic [ID_W-1:0]               grant_id,
  output logic                          busy,
  output logic                          proto_err
`ifdef NOC_INJECT_ARB_STATS_EN
  ,
  output logic [NUM_REQ*STATS_CNT_W-1:0] pkt_cnt
`endif
);

  arb_state_e            state;
  logic [ID_W-1:0]       rr_ptr;
  logic                  first_flit;
  logic [NUM_REQ-1:0]    cand;
  logic                  pick_any;
  logic [ID_W-1:0]       pick_idx;
  logic                  g_valid;
  logic                  g_hdr;
  logic                  g_tail;
  logic [DATA_WIDTH-1:0] g_flit;
  logic                  slot_free;
  logic                  accept;

  assign cand = req_valid & req_is_header;

  noc_rr_pick #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_pick (
    .cand (cand),
    .ptr  (rr_ptr),
    .any  (pick_any),
    .idx  (pick_idx)
  );

  assign g_valid   = req_valid[grant_id];
  assign g_hdr     = req_is_header[grant_id];
  assign g_tail    = req_is_tail[grant_id];
  assign g_flit    = req_flit[int'(grant_id)*DATA_WIDTH +: DATA_WIDTH];
  assign slot_free = !out_valid || out_ready;
  assign accept    = (state == ARB_LOCKED) && g_valid && slot_free;

  // Only the locked requester sees ready, and only when the output slot can take a flit.
  always_comb begin
    req_ready = '0;
    if (state == ARB_LOCKED) req_ready[grant_id] = slot_free;
  end

  // Arbitration FSM plus output register; tail acceptance releases the lock.
  always_ff @(posedge noc_clk or negedge noc_rst_n) begin
    if (!noc_rst_n) begin
      state         <= ARB_IDLE;
      rr_ptr        <= ID_W'(NUM_REQ - 1);
      grant_id      <= '0;
      busy          <= 1'b0;
      first_flit    <= 1'b0;
      proto_err     <= 1'b0;
      out_valid     <= 1'b0;
      out_flit      <= '0;
      out_is_header <= 1'b0;
      out_is_tail   <= 1'b0;
    end else begin
      proto_err <= 1'b0;

      if (accept) begin
        out_valid     <= 1'b1;
        out_flit      <= g_flit;
        out_is_header <= g_hdr;
        out_is_tail   <= g_tail;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end

      case (state)
        ARB_IDLE: begin
          if (pick_any) begin
            grant_id   <= pick_idx;
            busy       <= 1'b1;
            first_flit <= 1'b1;
            state      <= ARB_LOCKED;
          end
        end
        ARB_LOCKED: begin
          if (accept) begin
            first_flit <= 1'b0;
            // first flit must be a header, later ones must not be
            proto_err  <= first_flit ? !g_hdr : g_hdr;
            if (g_tail) begin
              rr_ptr <= grant_id;
              busy   <= 1'b0;
              state  <= ARB_IDLE;
            end
          end
        end
        default: state <= ARB_IDLE;
      endcase
    end
  end

`ifdef NOC_INJECT_ARB_STATS_EN
  logic [STATS_CNT_W-1:0] cnt_q [NUM_REQ];

  // Count completed packets per requester; counters wrap naturally.
  always_ff @(posedge noc_clk or negedge noc_rst_n) begin
    if (!noc_rst_n) begin
      for (int i = 0; i < NUM_REQ; i++) cnt_q[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (accept && g_tail && (grant_id == ID_W'(i))) cnt_q[i] <= cnt_q[i] + 1'b1;
      end
    end
  end

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_cnt
    assign pkt_cnt[gi*STATS_CNT_W +: STATS_CNT_W] = cnt_q[gi];
  end
`endif

endmodule

// File: tb/tb_noc_inject_arbiter.sv
// Directed self-checking bench for noc_inject_arbiter (4 requesters, 8-bit flits).
module tb_noc_inject_arbiter;

  localparam int NUM_REQ = 4;
  localparam int DW      = 8;

  logic                  noc_clk = 1'b0;
  logic                  noc_rst_n;
  logic [NUM_REQ-1:0]    req_valid;
  logic [NUM_REQ-1:0]    req_ready;
  logic [NUM_REQ*DW-1:0] req_flit;
  logic [NUM_REQ-1:0]    req_is_header;
  logic [NUM_REQ-1:0]    req_is_tail;
  logic                  out_valid;
  logic                  out_ready;
  logic [DW-1:0]         out_flit;
  logic                  out_is_header;
  logic                  out_is_tail;
  logic [1:0]            grant_id;
  logic                  busy;
  logic                  proto_err;
`ifdef NOC_INJECT_ARB_STATS_EN
  logic [NUM_REQ*16-1:0] pkt_cnt;
`endif

  int compared   = 0;
  int mismatched = 0;

  noc_inject_arbiter #(
    .NUM_REQ    (NUM_REQ),
    .DATA_WIDTH (DW)
  ) dut (
    .noc_clk       (noc_clk),
    .noc_rst_n     (noc_rst_n),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_flit      (req_flit),
    .req_is_header (req_is_header),
    .req_is_tail   (req_is_tail),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_flit      (out_flit),
    .out_is_header (out_is_header),
    .out_is_tail   (out_is_tail),
    .grant_id      (grant_id),
    .busy          (busy),
    .proto_err     (proto_err)
`ifdef NOC_INJECT_ARB_STATS_EN
    ,
    .pkt_cnt       (pkt_cnt)
`endif
  );

  always #5 noc_clk = ~noc_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int i, input logic v, input logic [DW-1:0] f,
                         input logic h, input logic t);
    req_valid[i]         = v;
    req_flit[i*DW +: DW] = f;
    req_is_header[i]     = h;
    req_is_tail[i]       = t;
  endtask

  task automatic clear_reqs();
    req_valid     = '0;
    req_flit      = '0;
    req_is_header = '0;
    req_is_tail   = '0;
  endtask

  task automatic cyc();
    @(posedge noc_clk);
    #1;
  endtask

  task automatic do_reset();
    noc_rst_n = 1'b0;
    clear_reqs();
    out_ready = 1'b1;
    @(posedge noc_clk);
    #1;
    noc_rst_n = 1'b1;
  endtask

  logic [DW-1:0] rr_exp [6] = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h10, 8'h11};

  initial begin
    noc_rst_n = 1'b0;
    clear_reqs();
    out_ready = 1'b1;
    #3;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_grant_id", grant_id, 0);
    chk("rst_proto_err", proto_err, 0);
    chk("rst_out_flit", out_flit, 0);
    chk("rst_out_hdr_tail", {out_is_header, out_is_tail}, 0);
`ifdef NOC_INJECT_ARB_STATS_EN
    chk("rst_pkt_cnt_lo", pkt_cnt[31:0], 0);
    chk("rst_pkt_cnt_hi", pkt_cnt[63:32], 0);
`endif
    @(posedge noc_clk);
    #1;
    noc_rst_n = 1'b1;

    // single requester, 3-flit packet
    set_req(0, 1, 8'hA1, 1, 0);
    #1;
    chk("t1_ready_idle", req_ready, 0);
    cyc();
    chk("t1_busy_grant", busy, 1);
    chk("t1_grant_id", grant_id, 0);
    chk("t1_no_xfer_on_grant", out_valid, 0);
    chk("t1_ready_locked", req_ready, 4'b0001);
    cyc();
    chk("t1_a1_valid", out_valid, 1);
    chk("t1_a1_flit", out_flit, 8'hA1);
    chk("t1_a1_hdr", out_is_header, 1);
    set_req(0, 1, 8'hA2, 0, 0);
    cyc();
    chk("t1_a2_flit", out_flit, 8'hA2);
    chk("t1_a2_hdr", out_is_header, 0);
    set_req(0, 1, 8'hA3, 0, 1);
    cyc();
    chk("t1_a3_flit", out_flit, 8'hA3);
    chk("t1_a3_tail", out_is_tail, 1);
    chk("t1_busy_drop", busy, 0);
    chk("t1_proto_err", proto_err, 0);
    set_req(0, 0, 8'h00, 0, 0);
    cyc();
    chk("t1_drain", out_valid, 0);

    // round-robin among four single-flit packets
    do_reset();
    for (int i = 0; i < NUM_REQ; i++) set_req(i, 1, 8'h10 + 8'(i), 1, 1);
    cyc();
    chk("t2_first_grant", grant_id, 0);
    for (int k = 0; k < 6; k++) begin
      cyc();
      chk("t2_valid", out_valid, 1);
      chk("t2_order", out_flit, rr_exp[k]);
      chk("t2_hdr", out_is_header, 1);
      cyc();
      chk("t2_idle_gap", out_valid, 0);
      chk("t2_next_grant", grant_id, (k + 1) % NUM_REQ);
    end
    clear_reqs();

    // no interleave: req2 waits for req1's 5-flit packet
    do_reset();
    set_req(1, 1, 8'hB1, 1, 0);
    cyc();
    chk("t3_grant1", grant_id, 1);
    cyc();
    chk("t3_b1", out_flit, 8'hB1);
    set_req(2, 1, 8'hC1, 1, 1);
    for (int j = 1; j < 5; j++) begin
      set_req(1, 1, 8'hB1 + 8'(j), 0, (j == 4));
      #1;
      chk("t3_req2_blocked", req_ready, 4'b0010);
      cyc();
      chk("t3_body", out_flit, 8'hB1 + 8'(j));
      chk("t3_still_g1", grant_id, 1);
    end
    chk("t3_tail", out_is_tail, 1);
    chk("t3_busy_off", busy, 0);
    set_req(1, 0, 8'h00, 0, 0);
    cyc();
    chk("t3_grant2", grant_id, 2);
    chk("t3_busy_on", busy, 1);
    cyc();
    chk("t3_c1", out_flit, 8'hC1);
    chk("t3_c1_hdr", out_is_header, 1);
    clear_reqs();

    // backpressure mid-packet
    do_reset();
    set_req(0, 1, 8'hD1, 1, 0);
    cyc();
    cyc();
    chk("t4_d1", out_flit, 8'hD1);
    set_req(0, 1, 8'hD2, 0, 0);
    cyc();
    chk("t4_d2", out_flit, 8'hD2);
    out_ready = 1'b0;
    set_req(0, 1, 8'hD3, 0, 0);
    #1;
    chk("t4_stall_ready", req_ready, 0);
    repeat (4) begin
      cyc();
      chk("t4_stall_flit", out_flit, 8'hD2);
      chk("t4_stall_valid", out_valid, 1);
      chk("t4_stall_ready_hold", req_ready, 0);
    end
    out_ready = 1'b1;
    #1;
    chk("t4_resume_ready", req_ready, 4'b0001);
    cyc();
    chk("t4_d3", out_flit, 8'hD3);
    set_req(0, 1, 8'hD4, 0, 1);
    cyc();
    chk("t4_d4", out_flit, 8'hD4);
    chk("t4_d4_tail", out_is_tail, 1);
    clear_reqs();
    cyc();
    chk("t4_drain", out_valid, 0);

    // protocol error: second header inside a packet
    do_reset();
    set_req(3, 1, 8'hE1, 1, 0);
    cyc();
    chk("t5_grant3", grant_id, 3);
    cyc();
    chk("t5_e1_flit", out_flit, 8'hE1);
    chk("t5_no_err", proto_err, 0);
    set_req(3, 1, 8'hE2, 1, 0);
    cyc();
    chk("t5_err_pulse", proto_err, 1);
    chk("t5_e2_forwarded", out_flit, 8'hE2);
    set_req(3, 1, 8'hE3, 0, 1);
    cyc();
    chk("t5_err_one_cycle", proto_err, 0);
    chk("t5_e3_flit", out_flit, 8'hE3);
    clear_reqs();
    cyc();
    chk("t5_idle_err", proto_err, 0);
`ifdef NOC_INJECT_ARB_STATS_EN
    chk("t5_pkt_cnt3", pkt_cnt[63:48], 1);
    chk("t5_pkt_cnt0", pkt_cnt[15:0], 0);
`endif

    // reset in the middle of a 4-flit packet
    set_req(0, 1, 8'hF1, 1, 0);
    cyc();
    cyc();
    set_req(0, 1, 8'hF2, 0, 0);
    cyc();
    chk("t6_f2", out_flit, 8'hF2);
    set_req(0, 1, 8'hF3, 0, 0);
    #2;
    noc_rst_n = 1'b0;
    #1;
    chk("t6_async_valid", out_valid, 0);
    chk("t6_async_busy", busy, 0);
    chk("t6_async_flit", out_flit, 0);
`ifdef NOC_INJECT_ARB_STATS_EN
    chk("t6_pkt_cnt_lo", pkt_cnt[31:0], 0);
    chk("t6_pkt_cnt_hi", pkt_cnt[63:32], 0);
`endif
    @(posedge noc_clk);
    #1;
    noc_rst_n = 1'b1;
    set_req(0, 1, 8'h61, 1, 1);
    set_req(1, 1, 8'h71, 1, 1);
    cyc();
    chk("t6_regrant0", grant_id, 0);
    chk("t6_regrant_busy", busy, 1);
    cyc();
    chk("t6_g1_flit", out_flit, 8'h61);
    clear_reqs();
    cyc();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
